// File: rtl/shift_reg_universal.sv
// shift_reg_universal: WIDTH-generic shift/rotate register with parallel load,
// serial in/out and a counted multi-shift (start/busy/done) operation.
module shift_reg_universal #(
  parameter int WIDTH = 6,
  parameter int AMT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] load,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] shr,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shr_q, shr_d, step;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d, act_mode;
  logic done_q, done_d;
  // A counted run uses the mode latched at start; IDLE shifts follow the live input.
  assign act_mode = state_q == RUN ? mode_q : mode;
  always_comb begin
    step = act_mode == 2'b00 ? {shr_q[WIDTH-2:0], sin} :
           act_mode == 2'b01 ? {sin, shr_q[WIDTH-1:1]} :
           act_mode == 2'b10 ? {shr_q[WIDTH-2:0], shr_q[WIDTH-1]} :
                               {shr_q[0], shr_q[WIDTH-1:1]};
  end
  always_comb begin
    state_d = state_q;
    shr_d = shr_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (ld) shr_d = load;
      else if (start) begin
        mode_d = mode;
        if (amount == '0) done_d = 1'b1;
        else begin
          cnt_d = amount;
          state_d = RUN;
        end
      end else if (en) shr_d = step;
    end else if (en) begin
      shr_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == AMT_W'(1)) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shr_q <= RESET_VAL;
      cnt_q <= '0;
      mode_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shr_q <= shr_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end
  assign shr = shr_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign sout = act_mode[0] ? shr_q[0] : shr_q[WIDTH-1];
endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register. It is the successor to the fixed 6-bit left shifter and is WIDTH-generic, with four shift/rotate modes, serial in/out and a parallel load separate from reset. It adds a counted multi-shift operation with a start/busy/done handshake, so a controller can request N shifts and wait for completion. It sits in datapaths as a serialiser/deserialiser or barrel-shift substitute.

Parameters:
WIDTH, 6, register width in bits (>=2)
AMT_W, 4, width of shift-amount input; amounts 0..2^AMT_W-1
RESET_VAL, 0, value of shr after reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
en  input  1  shift enable; qualifies every shift (single-step and counted)
ld  input  1  parallel load strobe
load  input  WIDTH  parallel load value
mode  input  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right
sin  input  1  serial fill bit for modes 00/01; ignored for rotates
start  input  1  begin counted shift of `amount` steps
amount  input  AMT_W  number of shifts for counted operation
shr  output  WIDTH  register contents
sout  output  1  bit that the next shift will expel: shr[WIDTH-1] for left modes, shr[0] for right modes (combinational from shr and the active mode)
busy  output  1  counted operation in progress
done  output  1  one-cycle pulse, counted operation complete

Behaviour:
- Reset: asynchronous, active-high. It forces shr=RESET_VAL, busy=0, done=0, cnt=0, latched mode=00 and state=IDLE immediately, regardless of clk. A reset mid-operation aborts the operation, and no done pulse follows.
- Shift step, per active mode:
  - 00: shr <= {shr[W-2:0], sin}
  - 01: shr <= {sin, shr[W-1:1]}
  - 10: shr <= {shr[W-2:0], shr[W-1]}
  - 11: shr <= {shr[0], shr[W-1:1]}
- Two states, IDLE and RUN. done is a registered pulse that defaults to 0 on every edge unless set below.
- IDLE, priority at each rising edge:
  - ld=1: shr <= load. start and en are ignored that cycle.
  - else start=1:
    - Latch mode into mode_q.
    - If amount=0: done <= 1, stay IDLE, shr unchanged.
    - Otherwise: cnt <= amount, busy <= 1, go to RUN. No shift on this edge.
  - else en=1: single shift using the live mode input. With mode=00 and sin=0 this matches the legacy 6-bit behaviour.
  - else hold.
- RUN, at each rising edge:
  - en=1: shift using mode_q, cnt <= cnt-1. If cnt==1: busy <= 0, done <= 1, go to IDLE.
  - en=0: stall; shr and cnt hold and busy stays 1.
  - ld and start are ignored (no queueing).
  - mode input changes are ignored; sin is sampled live every shift edge.
  - sout in RUN uses mode_q.
- Latency: start at edge E0 with amount=N and en held high gives shifts at E1..EN. busy is high from after E0 until EN. done is high for the single cycle after EN. A new start is accepted on the edge at which done is high.
- Amounts greater than WIDTH are legal. Logical shifts then saturate to all-sin; rotates wrap modulo WIDTH.
- sin is used only in modes 00/01.

Test Plan:
1. WIDTH=6. Drive ld=1, load=6'b000101, then en=1, mode=00, sin=0 for 3 cycles -> shr=001010, 010100, 101000; sout=1 after the third shift.
2. shr=6'b100011. Drive start with amount=2, mode=11, en=1 -> E1 shr=110001, E2 shr=111000; busy high 2 cycles; done high exactly 1 cycle after E2; sout tracks shr[0].
3. Counted run with amount=3, mode=10, from 6'b000001, with en low for 2 cycles after the first shift -> shr stays 000010 and busy stays 1 during the stall; the final value is 001000 and done is asserted 2 cycles later than unstalled.
4. Drive start with amount=0 -> done pulses on the next cycle, busy never asserts, shr unchanged. Separately, ld and start together in IDLE -> load wins and no busy.
5. During RUN, pulse ld=1 with load=6'b111111 and change mode -> both ignored and the run completes with the latched mode. Then assert rst asynchronously mid-run, between edges -> shr=RESET_VAL, busy=0 immediately, and no done pulse follows.
6. Drive start with amount=8, mode=00, sin=1 on WIDTH=6 from 6'b000000 -> final shr=111111 after 8 shifts, done 1 cycle later.
